// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide unit.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MTHI  = 3'd4,
    MTLO  = 3'd5
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2
  } mdu_state_t;

  function automatic logic is_signed_op(input mdu_op_t o);
    return (o == MULT) || (o == DIV);
  endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One iteration of the shift-add multiplier or restoring divider on a
// 2*WIDTH accumulator ({hi_part, lo_part}); purely combinational.
module mdu_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic                 is_div,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     opnd,
  output logic [2*WIDTH-1:0]   acc_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] diff;
  logic             step_unused;

  assign step_unused = diff[WIDTH];

  // Divide: shift {rem,quo} left and trial-subtract; multiply: add then shift right.
  always_comb begin
    sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    rem_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff   = {1'b0, rem_sh} - {2'b00, opnd};
    if (is_div) begin
      if (!diff[WIDTH+1]) begin
        acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end else if (acc[0]) begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end else begin
      acc_next = {1'b0, acc[2*WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Sequenced multiply/divide unit with architectural HI/LO registers.
// Optional MDU_FAST_MULT_EN: single-cycle combinational multiply path.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdu_op_t            op_e;
  mdu_state_t         state;
  logic [CNT_W-1:0]   counter;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;
  logic               is_signed;
  logic               sign_ab;
  logic               sign_a;
  logic               is_div;
  logic               neg_lo;
  logic               neg_hi;
  logic               div0;
  logic               commit;

  assign op_e = mdu_op_t'(op);

  // Operand magnitudes and result signs for the start cycle.
  always_comb begin
    is_signed = is_signed_op(op_e);
    a_abs     = (is_signed && a[WIDTH-1]) ? -a : a;
    b_abs     = (is_signed && b[WIDTH-1]) ? -b : b;
    sign_ab   = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
    sign_a    = is_signed && a[WIDTH-1];
  end

`ifdef MDU_FAST_MULT_EN
  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;
  logic [2*WIDTH-1:0] fast_prod;

  // Sign- or zero-extended full product; low 2*WIDTH bits are exact either way.
  always_comb begin
    if (op_e == MULT) begin
      a_ext = {{WIDTH{a[WIDTH-1]}}, a};
      b_ext = {{WIDTH{b[WIDTH-1]}}, b};
    end else begin
      a_ext = {{WIDTH{1'b0}}, a};
      b_ext = {{WIDTH{1'b0}}, b};
    end
    fast_prod = a_ext * b_ext;
  end
`endif

  mdu_iter_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (is_div),
    .acc      (acc),
    .opnd     (opnd),
    .acc_next (acc_next)
  );

  // Product is negated across the full 2*WIDTH; divide results per half.
  always_comb begin
    prod_fix = neg_lo ? -acc : acc;
    if (div0) begin
      fix_hi = hi;
      fix_lo = lo;
    end else if (is_div) begin
      fix_hi = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      fix_lo = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    end else begin
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo = prod_fix[WIDTH-1:0];
    end
  end

  // Control FSM, datapath registers and architectural HI/LO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      counter <= {CNT_W{1'b0}};
      acc     <= {(2*WIDTH){1'b0}};
      opnd    <= {WIDTH{1'b0}};
      res_hi  <= {WIDTH{1'b0}};
      res_lo  <= {WIDTH{1'b0}};
      hi      <= {WIDTH{1'b0}};
      lo      <= {WIDTH{1'b0}};
      is_div  <= 1'b0;
      neg_lo  <= 1'b0;
      neg_hi  <= 1'b0;
      div0    <= 1'b0;
      commit  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (commit) begin
            hi     <= res_hi;
            lo     <= res_lo;
            done   <= 1'b1;
            busy   <= 1'b0;
            commit <= 1'b0;
          end else if (start) begin
            case (op_e)
              MTHI: hi <= a;
              MTLO: lo <= a;
              MULT, MULTU: begin
                is_div <= 1'b0;
                div0   <= 1'b0;
                neg_hi <= 1'b0;
                busy   <= 1'b1;
`ifdef MDU_FAST_MULT_EN
                acc    <= fast_prod;
                neg_lo <= 1'b0;
                state  <= FIXUP;
`else
                acc     <= {{WIDTH{1'b0}}, b_abs};
                opnd    <= a_abs;
                neg_lo  <= sign_ab;
                counter <= CNT_W'(WIDTH - 1);
                state   <= CALC;
`endif
              end
              DIV, DIVU: begin
                is_div  <= 1'b1;
                busy    <= 1'b1;
                acc     <= {{WIDTH{1'b0}}, a_abs};
                opnd    <= b_abs;
                neg_lo  <= sign_ab;
                neg_hi  <= sign_a;
                counter <= CNT_W'(WIDTH - 1);
                if (b == {WIDTH{1'b0}}) begin
                  div0  <= 1'b1;
                  state <= FIXUP;
                end else begin
                  div0  <= 1'b0;
                  state <= CALC;
                end
              end
              default: ;
            endcase
          end
        end
        CALC: begin
          acc <= acc_next;
          if (counter == {CNT_W{1'b0}}) begin
            state <= FIXUP;
          end else begin
            counter <= counter - CNT_W'(1);
          end
        end
        FIXUP: begin
          res_hi <= fix_hi;
          res_lo <= fix_lo;
          commit <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Randomized and directed bench for mdu_sequencer against a 64-bit arithmetic model.
module tb_mdu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_hl;

`ifdef MDU_FAST_MULT_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT = 34;

  mdu_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  // Architectural result {hi,lo} from plain 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x,
                                        input logic [31:0] y, input logic [63:0] cur);
    longint          sx, sy, q, r;
    longint unsigned ux, uy, uq, ur;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      3'd0: return 64'(sx * sy);
      3'd1: return ux * uy;
      3'd2: begin
        if (y == 32'd0) return cur;
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (y == 32'd0) return cur;
        uq = ux / uy;
        ur = ux % uy;
        return {ur[31:0], uq[31:0]};
      end
      3'd4: return {x, cur[31:0]};
      3'd5: return {cur[63:32], x};
      default: return cur;
    endcase
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [31:0] xa, input logic [31:0] xb,
                        input int inj, input logic [2:0] iop, input logic [31:0] ia);
    logic [63:0] nxt;
    int          lat, n, bad;
    nxt = model(o, xa, xb, exp_hl);
    @(negedge clk);
    start = 1'b1; op = o; a = xa; b = xb;
    @(posedge clk); #1;
    start = 1'b0;
    if (o == 3'd4 || o == 3'd5) begin
      check("mt_hilo", {hi, lo}, nxt);
      check("mt_flags", {62'd0, busy, done}, 64'd0);
    end else begin
      if (o == 3'd0 || o == 3'd1) lat = MUL_LAT;
      else if (xb == 32'd0) lat = 2;
      else lat = DIV_LAT;
      check("busy_rise", {63'd0, busy}, 64'd1);
      n = 0;
      bad = 0;
      while (!done && n < 100) begin
        if (n == inj) begin
          start = 1'b1; op = iop; a = ia;
        end
        @(posedge clk); #1;
        start = 1'b0;
        n++;
        if (!done && (!busy || {hi, lo} !== exp_hl)) bad++;
      end
      check("latency", 64'(n), 64'(lat));
      check("busy_hold", 64'(bad), 64'd0);
      check("busy_fall", {63'd0, busy}, 64'd0);
      check("result", {hi, lo}, nxt);
      @(posedge clk); #1;
      check("done_pulse", {63'd0, done}, 64'd0);
    end
    exp_hl = nxt;
  endtask

  initial begin
    int seen;
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    reset = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
    exp_hl = 64'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {30'd0, busy, done, hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 3'd0, 32'd0);
    run_op(3'd0, 32'hFFFFFFFD, 32'd5, -1, 3'd0, 32'd0);
    run_op(3'd2, 32'hFFFFFFF9, 32'd2, -1, 3'd0, 32'd0);
    run_op(3'd3, 32'd7, 32'd2, -1, 3'd0, 32'd0);
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, -1, 3'd0, 32'd0);
    run_op(3'd5, 32'h00001234, 32'd0, -1, 3'd0, 32'd0);
    run_op(3'd3, 32'd5, 32'd0, -1, 3'd0, 32'd0);
    run_op(3'd0, 32'h12345678, 32'h9ABCDEF0, 0, 3'd4, 32'hDEADBEEF);
    run_op(3'd2, 32'h7FFFFFFF, 32'h80000000, 5, 3'd5, 32'hCAFEF00D);

    // Abort a multiply mid-calculation with an asynchronous reset.
    @(negedge clk);
    start = 1'b1; op = 3'd1; a = 32'hABCDEF01; b = 32'h13579BDF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_state", {30'd0, busy, done, hi, lo}, 64'd0);
    exp_hl = 64'd0;
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    check("abort_quiet", 64'(seen), 64'd0);
    run_op(3'd3, 32'd100, 32'd7, -1, 3'd0, 32'd0);

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 5));
      ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 1000)) : 32'($urandom);
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      else if ($urandom_range(0, 1) == 0) rb = 32'($urandom_range(1, 50));
      else rb = 32'($urandom);
      run_op(ro, ra, rb, -1, 3'd0, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
